// File: rtl/imm_gen_component_if.sv
// Instruction-in / immediate-out bundle for the immediate generator.
// The datapath drives inst, and the generator returns out.
interface imm_gen_component_if;
  logic [15:0] inst;
  logic [15:0] out;

  modport master (output inst, input out);
  modport slave  (input inst, output out);
endinterface

// File: rtl/imm_gen_component.sv
// Immediate generator for the 16-bit datapath: decodes inst[3:0] into an
// upper-placed byte, a zero-extended 5-bit shift amount, or a sign-extended byte.
module imm_gen_component (
  input  logic                      clock,
  input  logic                      reset,
  imm_gen_component_if.slave        bus
);

  typedef enum logic [3:0] {
    OP_UPPER = 4'b0101,
    OP_SHAMT = 4'b0110
  } opcode_e;

  opcode_e     opcode;
  logic [7:0]  imm8;
  logic [4:0]  imm5;
  logic [15:0] decoded;

  assign opcode = opcode_e'(bus.inst[3:0]);
  assign imm8   = bus.inst[15:8];
  assign imm5   = bus.inst[12:8];

  always_comb begin
    decoded = '0;
    case (opcode)
      OP_UPPER: decoded = {imm8, 8'h00};
      OP_SHAMT: decoded = {11'b0, imm5};
      default:  decoded = {{8{imm8[7]}}, imm8};
    endcase
  end

  // Purely combinational, so reset gates the output and needs no clock edge.
  assign bus.out = reset ? '0 : decoded;

  // The clock and the register-specifier bits are deliberately left unused.
  logic [4:0] unused_bits;
  assign unused_bits = {clock, bus.inst[7:4]};

endmodule

// File: tb/tb_imm_gen_component.sv
// Bench for imm_gen_component: directed plan cases plus random instructions
// compared against an arithmetic reference model.
module tb_imm_gen_component;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned total = 0;
  int unsigned bad   = 0;

  imm_gen_component_if bus ();

  imm_gen_component dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] model(input logic [15:0] inst, input logic rst);
    int unsigned op;
    int unsigned hi;
    int unsigned r;
    op = inst % 16;
    hi = inst / 256;
    if (rst) return 16'h0000;
    if (op == 5) r = hi * 256;
    else if (op == 6) r = hi % 32;
    else if (hi >= 128) r = 65536 - 256 + hi;
    else r = hi;
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    total++;
    assert (bus.out === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, bus.out, exp);
    end
  endtask

  task automatic apply(input logic [15:0] inst, input string tag, input logic [15:0] exp);
    bus.inst = inst;
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [15:0] r_inst;
    logic        r_rst;

    bus.inst = 16'h4B65;
    reset    = 1'b1;
    #2;
    check("reset_hold", 16'h0000);
    reset = 1'b0;
    #1;
    check("reset_release_no_edge", 16'h4B00);

    @(negedge clock);
    apply(16'b1001011010010110, "shamt_0016", 16'h0016);
    apply(16'hFF06, "shamt_001f", 16'h001F);
    apply(16'b0100101101100101, "upper_4b00", 16'h4B00);
    apply(16'hFF05, "upper_ff00", 16'hFF00);
    apply(16'b0010010111111000, "sext_pos_0025", 16'h0025);
    apply(16'h7F00, "sext_pos_007f", 16'h007F);
    apply(16'b1111001101011001, "sext_neg_fff3", 16'hFFF3);
    apply(16'h8000, "sext_neg_ff80", 16'hFF80);
    apply(16'h8005, "upper_8000", 16'h8000);
    apply(16'h8006, "shamt_ignores_sign", 16'h0000);
    apply(16'h1F06, "shamt_max", 16'h001F);

    bus.inst = 16'hF359;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("clock_independence", 16'hFFF3);
    end
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("reset_mid_cycle", 16'h0000);
    reset = 1'b0;
    #1;
    check("reset_mid_release", 16'hFFF3);

    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      r_inst = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r_inst[3:0] = 4'b0101;
        1: r_inst[3:0] = 4'b0110;
        default: ;
      endcase
      r_rst = ($urandom_range(0, 15) == 0);
      reset    = r_rst;
      bus.inst = r_inst;
      #1;
      check("random", model(r_inst, r_rst));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
